// File: rtl/mic_volume_meter_if.sv
// rtl/mic_volume_meter_if.sv - mic sample input and volume output bundle for mic_volume_meter.
// master drives samples and observes the level; slave is the meter itself.
interface mic_volume_meter_if #(
   parameter int SAMPLE_W = 12
);
   logic [SAMPLE_W-1:0] mic_in;
   logic                mic_valid;
   logic [4:0]          volume;
   logic                volume_valid;
   logic [SAMPLE_W-1:0] peak_out;

   modport master (
      output mic_in, mic_valid,
      input  volume, volume_valid, peak_out
   );

   modport slave (
      input  mic_in, mic_valid,
      output volume, volume_valid, peak_out
   );
endinterface

// File: rtl/mic_volume_meter.sv
// rtl/mic_volume_meter.sv - windowed peak-deviation meter producing a 0..MAX_LEVEL volume level.
// Optional MIC_VOLUME_DECAY_EN: falling levels step down by one per window instead of jumping.
module mic_volume_meter #(
   parameter int SAMPLE_W  = 12,
   parameter int WINDOW    = 4096,
   parameter int OFFSET    = 2048,
   parameter int SHIFT     = 7,
   parameter int MAX_LEVEL = 15
) (
   input  logic                clk,
   input  logic                rst,
   mic_volume_meter_if.slave   bus
);
   localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam logic [SAMPLE_W-1:0] MID      = SAMPLE_W'(OFFSET);
   localparam logic [SAMPLE_W-1:0] LVL_MAX  = SAMPLE_W'(MAX_LEVEL);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(WINDOW - 1);

   logic [SAMPLE_W-1:0] peak;
   logic [CNT_W-1:0]    count;
   logic [SAMPLE_W-1:0] mag;
   logic [SAMPLE_W-1:0] final_peak;
   logic [SAMPLE_W-1:0] shifted;
   logic [4:0]          level;
   logic [4:0]          next_volume;
   logic                last;

   always_comb begin
      mag        = (bus.mic_in >= MID) ? (bus.mic_in - MID) : (MID - bus.mic_in);
      final_peak = (mag > peak) ? mag : peak;
      shifted    = final_peak >> SHIFT;
      level      = (shifted > LVL_MAX) ? 5'(MAX_LEVEL) : shifted[4:0];
      last       = (count == CNT_LAST);
`ifdef MIC_VOLUME_DECAY_EN
      // Rises are shown at once; falls bleed off one step per window so the bar does not flicker.
      next_volume = (level >= bus.volume) ? level : (bus.volume - 5'd1);
`else
      next_volume = level;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peak             <= '0;
         count            <= '0;
         bus.volume       <= '0;
         bus.volume_valid <= 1'b0;
         bus.peak_out     <= '0;
      end else begin
         bus.volume_valid <= 1'b0;
         if (bus.mic_valid) begin
            if (last) begin
               // The closing sample counts toward this window's peak.
               bus.peak_out     <= final_peak;
               bus.volume       <= next_volume;
               bus.volume_valid <= 1'b1;
               peak             <= '0;
               count            <= '0;
            end else begin
               peak  <= final_peak;
               count <= count + CNT_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_mic_volume_meter.sv
// tb/tb_mic_volume_meter.sv - self-checking bench for mic_volume_meter with WINDOW=16.
// Honours MIC_VOLUME_DECAY_EN in its reference model and expected sequences.
module tb_mic_volume_meter;
   localparam int WIN = 16;

   logic clk;
   logic rst;

   mic_volume_meter_if #(.SAMPLE_W(12)) bus ();

   mic_volume_meter #(.WINDOW(WIN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int fill;
      int last;
      int exp_level;
      int exp_peak;
   } vec_t;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int pulses = 0;
   int pulse_cyc[$];
   int win_q[$];
   int ref_vol = 0;
   int ref_peak = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: collect magnitudes of a whole window, then take max, shift, clamp.
   task automatic tick(input logic v, input int val);
      int pk;
      int lvl;
      bit exp_pulse;
      bus.mic_valid = v;
      bus.mic_in    = 12'(val);
      @(posedge clk);
      #1;
      cyc++;
      exp_pulse = 1'b0;
      if (v) begin
         win_q.push_back((val >= 2048) ? (val - 2048) : (2048 - val));
         if (win_q.size() == WIN) begin
            pk = 0;
            foreach (win_q[i]) if (win_q[i] > pk) pk = win_q[i];
            lvl = pk / 128;
            if (lvl > 15) lvl = 15;
`ifdef MIC_VOLUME_DECAY_EN
            ref_vol = (lvl >= ref_vol) ? lvl : ref_vol - 1;
`else
            ref_vol = lvl;
`endif
            ref_peak = pk;
            win_q.delete();
            exp_pulse = 1'b1;
         end
      end
      check("volume_valid", int'(bus.volume_valid), int'(exp_pulse));
      check("volume", int'(bus.volume), ref_vol);
      check("peak_out", int'(bus.peak_out), ref_peak);
      if (bus.volume_valid) begin
         pulses++;
         pulse_cyc.push_back(cyc);
      end
   endtask

   task automatic do_reset();
      bus.mic_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      win_q.delete();
      ref_vol  = 0;
      ref_peak = 0;
   endtask

   task automatic window_of(input int fill, input int last);
      for (int i = 0; i < WIN - 1; i++) tick(1'b1, fill);
      tick(1'b1, last);
   endtask

   vec_t vecs[9];
   int dec_exp[4];
   int prev;
   int exp_vol;
   int base;
   int got;

   initial begin
      vecs[0] = '{2048, 2048,  0,    0};
      vecs[1] = '{2048, 2688,  5,  640};
      vecs[2] = '{4095, 4095, 15, 2047};
      vecs[3] = '{   0,    0, 15, 2048};
      vecs[4] = '{2048, 2176,  1,  128};
      vecs[5] = '{2048, 1920,  1,  128};
      vecs[6] = '{2048, 2047,  0,    1};
      vecs[7] = '{2048, 4000, 15, 1952};
      vecs[8] = '{2100, 2048,  0,   52};
`ifdef MIC_VOLUME_DECAY_EN
      dec_exp = '{12, 11, 10, 9};
`else
      dec_exp = '{12, 0, 0, 0};
`endif

      rst = 1'b1;
      bus.mic_valid = 1'b0;
      bus.mic_in = 12'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset volume", int'(bus.volume), 0);
      check("reset volume_valid", int'(bus.volume_valid), 0);
      check("reset peak_out", int'(bus.peak_out), 0);
      do_reset();

      // Table: fifteen fill samples plus one distinct closing sample.
      prev = 0;
      for (int k = 0; k < 9; k++) begin
         window_of(vecs[k].fill, vecs[k].last);
`ifdef MIC_VOLUME_DECAY_EN
         exp_vol = (vecs[k].exp_level >= prev) ? vecs[k].exp_level : prev - 1;
`else
         exp_vol = vecs[k].exp_level;
`endif
         check($sformatf("table%0d volume", k), int'(bus.volume), exp_vol);
         check($sformatf("table%0d peak_out", k), int'(bus.peak_out), vecs[k].exp_peak);
         check($sformatf("table%0d pulse", k), int'(bus.volume_valid), 1);
         prev = exp_vol;
      end
      tick(1'b0, 0);

      // Back-to-back samples: 48 valid cycles give three evenly spaced pulses.
      base = pulses;
      for (int i = 0; i < 48; i++) tick(1'b1, int'($urandom_range(0, 4095)));
      check("b2b pulse count", pulses - base, 3);
      if (pulse_cyc.size() >= 3) begin
         check("b2b spacing a", pulse_cyc[$] - pulse_cyc[$-1], 16);
         check("b2b spacing b", pulse_cyc[$-1] - pulse_cyc[$-2], 16);
      end

      // Random windows with random idle gaps; idle cycles carry garbage data.
      for (int w = 0; w < 4; w++) begin
         int n = 0;
         while (n < WIN) begin
            if ($urandom_range(0, 2) == 0) tick(1'b0, int'($urandom_range(0, 4095)));
            else begin
               tick(1'b1, int'($urandom_range(0, 4095)));
               n++;
            end
         end
      end
      tick(1'b0, 0);

      // Mid-window asynchronous reset discards the partial window.
      window_of(4095, 4095);
      check("pre-reset volume", int'(bus.volume), 15);
      for (int i = 0; i < 9; i++) tick(1'b1, 4095);
      bus.mic_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async reset volume", int'(bus.volume), 0);
      check("async reset peak_out", int'(bus.peak_out), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      win_q.delete();
      ref_vol  = 0;
      ref_peak = 0;
      base = pulses;
      for (int i = 0; i < WIN - 1; i++) tick(1'b1, 2048);
      check("post-reset no early pulse", pulses - base, 0);
      tick(1'b1, 2048);
      check("post-reset pulse", int'(bus.volume_valid), 1);
      check("post-reset volume", int'(bus.volume), 0);
      tick(1'b0, 0);

      // Level 12 then three silent windows.
      do_reset();
      for (int w = 0; w < 4; w++) begin
         window_of(2048, (w == 0) ? 3584 : 2048);
         got = int'(bus.volume);
         check($sformatf("decay step%0d", w), got, dec_exp[w]);
      end
      tick(1'b0, 0);
      check("pulse deasserted", int'(bus.volume_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
